mem_wb_stage_reg: RTL and testbench

//  - MEM->WB pipeline register of the 16-bit microRISC core; captures MEM-stage control/data on each clk edge.
//  - Presents registered values plus the selected write-back data and the register-file write enable to WB.
//  - Supports stall (hold) and flush (bubble insert) from the hazard unit.

---
 rtl/mem_wb_stage_reg_pkg.sv | 7 +
 rtl/mem_wb_stage_reg_wb_data_mux.sv | 11 +
 rtl/mem_wb_stage_reg.sv | 62 ++++++
 tb/tb_mem_wb_stage_reg.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_wb_stage_reg_pkg.sv
// mem_wb_stage_reg_pkg: shared widths and bubble constant for the MEM->WB stage register
package mem_wb_stage_reg_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int RETIRE_W = 32;
  localparam logic [63:0] BUBBLE = '0;
endpackage

// File: rtl/mem_wb_stage_reg_wb_data_mux.sv
// mem_wb_stage_reg_wb_data_mux: 2:1 write-back data select (sel=1 picks load data)
module mem_wb_stage_reg_wb_data_mux #(
  parameter int DATA_W = 16
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] load,
  output logic [DATA_W-1:0] y
);
  assign y = sel ? load : alu;
endmodule

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg: MEM->WB pipeline register with stall/flush; MEM_WB_RETIRE_CNT_EN adds retire_count
module mem_wb_stage_reg
  import mem_wb_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [DATA_W-1:0]     wb_alu_result,
  output logic [DATA_W-1:0]     wb_read_data,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0]     wb_write_data,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [RETIRE_W-1:0]   retire_count,
`endif
  output logic                  wb_rf_we
);
  // stage register: reset/flush insert a bubble, stall holds, otherwise capture MEM
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid      <= BUBBLE[0];
      wb_reg_write  <= BUBBLE[0];
      wb_mem_to_reg <= BUBBLE[0];
      wb_alu_result <= BUBBLE[DATA_W-1:0];
      wb_read_data  <= BUBBLE[DATA_W-1:0];
      wb_write_reg  <= BUBBLE[REG_ADDR_W-1:0];
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_mem_to_reg <= mem_mem_to_reg;
      wb_alu_result <= mem_alu_result;
      wb_read_data  <= mem_read_data;
      wb_write_reg  <= mem_write_reg;
    end
  end
`ifdef MEM_WB_RETIRE_CNT_EN
  // retire counter: counts valid instructions actually loaded; flush does not clear it
  always_ff @(posedge clk) begin
    if (rst) retire_count <= '0;
    else if (!flush && !stall && mem_valid) retire_count <= retire_count + 1'b1;
  end
`endif
  assign wb_rf_we = wb_valid & wb_reg_write;
  mem_wb_stage_reg_wb_data_mux #(.DATA_W(DATA_W)) u_mux (
    .sel  (wb_mem_to_reg),
    .alu  (wb_alu_result),
    .load (wb_read_data),
    .y    (wb_write_data)
  );
endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// tb_mem_wb_stage_reg: directed scoreboard bench for mem_wb_stage_reg
module tb_mem_wb_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, stall = 1'b0;
  logic mem_valid = 1'b0, mem_reg_write = 1'b0, mem_mem_to_reg = 1'b0;
  logic [15:0] mem_alu_result = '0, mem_read_data = '0;
  logic [2:0] mem_write_reg = '0;
  logic wb_valid, wb_reg_write, wb_mem_to_reg, wb_rf_we;
  logic [15:0] wb_alu_result, wb_read_data, wb_write_data;
  logic [2:0] wb_write_reg;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif
  int tests = 0, fails = 0;

  typedef struct packed {
    logic        v, rw, m2r;
    logic [15:0] alu, rd;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        we;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];

  mem_wb_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data), .mem_write_reg(mem_write_reg),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
`ifdef MEM_WB_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .wb_rf_we(wb_rf_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // monitor: one registered result appears after each edge; compare against the queued expectation
  initial begin
    int idx = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        idx++;
        chk("wb_valid", idx, 32'(wb_valid), 32'(e.v));
        chk("wb_reg_write", idx, 32'(wb_reg_write), 32'(e.rw));
        chk("wb_mem_to_reg", idx, 32'(wb_mem_to_reg), 32'(e.m2r));
        chk("wb_alu_result", idx, 32'(wb_alu_result), 32'(e.alu));
        chk("wb_read_data", idx, 32'(wb_read_data), 32'(e.rd));
        chk("wb_write_reg", idx, 32'(wb_write_reg), 32'(e.wr));
        chk("wb_write_data", idx, 32'(wb_write_data), 32'(e.wd));
        chk("wb_rf_we", idx, 32'(wb_rf_we), 32'(e.we));
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("retire_count", idx, retire_count, e.cnt);
`endif
      end
    end
  end

  task automatic vec(input logic r, f, s, v, rw, m2r, input logic [15:0] alu, rd, input logic [2:0] wr, input exp_t e);
    @(negedge clk);
    rst = r; flush = f; stall = s;
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r;
    mem_alu_result = alu; mem_read_data = rd; mem_write_reg = wr;
    q.push_back(e);
  endtask

  initial begin
    int guard = 0;
    //   rst f s v rw m2r alu       rd        wr           v  rw m2r alu       rd        wr    wd        we cnt
    vec(1, 0, 0, 1, 1, 1, 16'hFFFF, 16'hEEEE, 3'd7, '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 0, 0});
    vec(0, 0, 0, 1, 1, 1, 16'hABCD, 16'h1234, 3'd5, '{1, 1, 1, 16'hABCD, 16'h1234, 3'd5, 16'h1234, 1, 1});
    vec(0, 0, 0, 1, 1, 0, 16'hABCD, 16'h1234, 3'd5, '{1, 1, 0, 16'hABCD, 16'h1234, 3'd5, 16'hABCD, 1, 2});
    vec(0, 0, 1, 1, 1, 1, 16'h5555, 16'h6666, 3'd2, '{1, 1, 0, 16'hABCD, 16'h1234, 3'd5, 16'hABCD, 1, 2});
    vec(0, 0, 1, 0, 0, 1, 16'h1111, 16'h2222, 3'd1, '{1, 1, 0, 16'hABCD, 16'h1234, 3'd5, 16'hABCD, 1, 2});
    vec(0, 1, 1, 1, 1, 1, 16'h5555, 16'h6666, 3'd2, '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 0, 2});
    vec(0, 0, 0, 0, 1, 0, 16'h0F0F, 16'hF0F0, 3'd3, '{0, 1, 0, 16'h0F0F, 16'hF0F0, 3'd3, 16'h0F0F, 0, 2});
    vec(0, 0, 0, 1, 0, 1, 16'h0001, 16'h8000, 3'd0, '{1, 0, 1, 16'h0001, 16'h8000, 3'd0, 16'h8000, 0, 3});
    vec(0, 0, 0, 1, 1, 0, 16'hFFFF, 16'h0000, 3'd0, '{1, 1, 0, 16'hFFFF, 16'h0000, 3'd0, 16'hFFFF, 1, 4});
    vec(1, 0, 0, 1, 1, 1, 16'h9999, 16'h8888, 3'd4, '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 0, 0});
    vec(0, 0, 0, 1, 1, 1, 16'h7777, 16'h8888, 3'd7, '{1, 1, 1, 16'h7777, 16'h8888, 3'd7, 16'h8888, 1, 1});
    vec(0, 0, 0, 1, 1, 0, 16'h1234, 16'h5678, 3'd6, '{1, 1, 0, 16'h1234, 16'h5678, 3'd6, 16'h1234, 1, 2});
    vec(0, 1, 0, 1, 1, 1, 16'h4321, 16'h8765, 3'd2, '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 0, 2});
    vec(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 0, 2});
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
